// File: rtl/ram512_ctrl_if.sv
// Request/response bus between a client and the RAM sequencing front-end.
// The master issues requests and consumes responses; the slave is the controller.
interface ram512_ctrl_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram512_ctrl.sv
// Sequencing front-end for a 512x16 single-port RAM: clears the array after
// reset, then serves one write or read request at a time with a registered response.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_INIT  | writing INIT_VAL to address cnt, one word per cycle
// S_IDLE  | ready for a request; RAM disabled, address/data held
// S_WRITE | one-cycle RAM write of the latched address/data
// S_READ  | one-cycle RAM read; ram_dout captured on the exiting edge
// S_RESP  | response valid, waiting for the consumer handshake
module ram512_ctrl #(
    parameter int            AW       = 9,
    parameter int            DW       = 16,
    parameter bit            INIT_EN  = 1'b1,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_,
    ram512_ctrl_if.slave  bus,
    output logic          busy,
    output logic          ram_e,
    output logic          ram_w,
    output logic          ram_r,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP
    } state_t;

    localparam state_t        RST_STATE = INIT_EN ? S_INIT : S_IDLE;
    localparam logic [AW-1:0] CNT_LAST  = '1;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] cnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic [DW-1:0] rdata_q;

    logic          ready_c;
    logic          valid_c;
    logic          e_c;
    logic          w_c;
    logic          r_c;
    logic          accept;
    logic          init_act;

    assign accept = (state == S_IDLE) && bus.req_valid;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= RST_STATE;
            cnt     <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (state == S_INIT) begin
                cnt    <= cnt + 1'b1;
                addr_q <= cnt;
                din_q  <= INIT_VAL;
            end
            if (accept) begin
                addr_q <= bus.req_addr;
                din_q  <= bus.req_wdata;
            end
            if (state == S_READ) begin
                rdata_q <= ram_dout;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ready_c  = 1'b0;
        valid_c  = 1'b0;
        e_c      = 1'b0;
        w_c      = 1'b0;
        r_c      = 1'b0;
        case (state)
            S_INIT: begin
                e_c = 1'b1;
                w_c = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nx = S_IDLE;
                end
            end
            S_IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) begin
                    state_nx = bus.req_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                e_c      = 1'b1;
                w_c      = 1'b1;
                state_nx = S_IDLE;
            end
            S_READ: begin
                e_c      = 1'b1;
                r_c      = 1'b1;
                state_nx = S_RESP;
            end
            S_RESP: begin
                valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = RST_STATE;
            end
        endcase
    end

    // Strobes and handshakes are masked while rst_ is held so the reset state
    // (INIT or IDLE) presents all-zero outputs and the RAM is never written in reset.
    assign init_act = (state == S_INIT) && rst_;

    assign busy          = (state == S_INIT);
    assign bus.req_ready = ready_c & rst_;
    assign bus.rsp_valid = valid_c & rst_;
    assign bus.rsp_rdata = rdata_q;
    assign ram_e         = e_c & rst_;
    assign ram_w         = w_c & rst_;
    assign ram_r         = r_c & rst_;
    assign ram_addr      = init_act ? cnt : addr_q;
    assign ram_din       = init_act ? INIT_VAL : din_q;

endmodule

// File: tb/tb_ram512_ctrl.sv
// Directed bench for ram512_ctrl: one instance clears the RAM after reset, a
// second skips init; both drive behavioural 512x16 RAM models.
module tb_ram512_ctrl;

    logic clk = 1'b0;
    logic rst_;
    logic seed;

    always #5 clk = ~clk;

    ram512_ctrl_if #(.AW(9), .DW(16)) bus0 ();
    ram512_ctrl_if #(.AW(9), .DW(16)) bus1 ();

    logic        busy0, ram_e0, ram_w0, ram_r0;
    logic [8:0]  ram_addr0;
    logic [15:0] ram_din0, ram_dout0;
    logic        busy1, ram_e1, ram_w1, ram_r1;
    logic [8:0]  ram_addr1;
    logic [15:0] ram_din1, ram_dout1;

    ram512_ctrl #(.AW(9), .DW(16), .INIT_EN(1'b1), .INIT_VAL(16'h0000)) u0 (
        .clk(clk), .rst_(rst_), .bus(bus0), .busy(busy0),
        .ram_e(ram_e0), .ram_w(ram_w0), .ram_r(ram_r0),
        .ram_addr(ram_addr0), .ram_din(ram_din0), .ram_dout(ram_dout0)
    );

    ram512_ctrl #(.AW(9), .DW(16), .INIT_EN(1'b0), .INIT_VAL(16'h0000)) u1 (
        .clk(clk), .rst_(rst_), .bus(bus1), .busy(busy1),
        .ram_e(ram_e1), .ram_w(ram_w1), .ram_r(ram_r1),
        .ram_addr(ram_addr1), .ram_din(ram_din1), .ram_dout(ram_dout1)
    );

    // RAM models; mem0 is pre-filled with junk so the clear is observable.
    logic [15:0] mem0 [512];
    logic [15:0] mem1 [512];

    always @(posedge clk) begin
        if (seed) begin
            for (int i = 0; i < 512; i++) mem0[i] <= 16'hDEAD;
        end else if (ram_e0 && ram_w0) begin
            mem0[ram_addr0] <= ram_din0;
        end
        if (ram_e1 && ram_w1) mem1[ram_addr1] <= ram_din1;
    end

    assign ram_dout0 = (ram_e0 && ram_r0) ? mem0[ram_addr0] : 16'hxxxx;
    assign ram_dout1 = (ram_e1 && ram_r1) ? mem1[ram_addr1] : 16'hxxxx;

    int   e_cnt0 = 0;
    logic both_seen = 1'b0;

    always @(posedge clk) if (ram_e0) e_cnt0 <= e_cnt0 + 1;
    always @(negedge clk) if ((ram_w0 && ram_r0) || (ram_w1 && ram_r1)) both_seen <= 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called right after reset release; samples 512 init cycles on DUT0.
    task automatic init_run(output int bad);
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            if (k == 10) bus0.req_valid = 1'b0;
            if (!(ram_e0 === 1'b1 && ram_w0 === 1'b1 && ram_r0 === 1'b0 &&
                  ram_addr0 === k[8:0] && ram_din0 === 16'h0000 &&
                  busy0 === 1'b1 && bus0.req_ready === 1'b0))
                bad++;
            @(negedge clk);
        end
    endtask

    task automatic do_write0(input logic [8:0] a, input logic [15:0] d);
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b1;
        bus0.req_addr  = a;
        bus0.req_wdata = d;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        chk("wr_pins", {ram_e0, ram_w0, ram_r0, ram_addr0, ram_din0}, {3'b110, a, d});
        @(negedge clk);
    endtask

    task automatic do_read0(input logic [8:0] a, output logic [15:0] d, output int lat);
        bus0.rsp_ready = 1'b1;
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b0;
        bus0.req_addr  = a;
        lat = 0;
        d   = 16'hxxxx;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus0.req_valid = 1'b0;
            lat++;
            if (bus0.rsp_valid === 1'b1) break;
        end
        if (bus0.rsp_valid !== 1'b1) lat = 99;
        else d = bus0.rsp_rdata;
        @(negedge clk);
    endtask

    logic [15:0] rd;
    int          lat;
    int          bad;
    int          snap;

    initial begin
        rst_ = 1'b0;
        seed = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus0.rsp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
        bus1.rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        seed = 1'b0;

        chk("rst_busy0", busy0, 1);
        chk("rst_pins0", {ram_e0, ram_w0, ram_r0, ram_addr0, ram_din0}, 0);
        chk("rst_hs0", {bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata}, 0);
        chk("rst_busy1_ready1", {busy1, bus1.req_ready}, 0);

        // Release; a write request held during init must be ignored.
        bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 9'h005; bus0.req_wdata = 16'h7777;
        rst_ = 1'b1;
        #1;
        init_run(bad);
        chk("init_seq", bad, 0);
        chk("post_init", {busy0, bus0.req_ready, ram_e0}, 3'b010);
        chk("post_init_addr_hold", ram_addr0, 9'h1FF);

        do_read0(9'h0A5, rd, lat);
        chk("rd_0a5", rd, 16'h0000);
        chk("rd_latency", lat, 2);
        do_read0(9'h005, rd, lat);
        chk("rd_ignored_init_req", rd, 16'h0000);

        do_write0(9'h1A5, 16'hBEEF);
        do_read0(9'h1A5, rd, lat);
        chk("rd_after_wr_1a5", rd, 16'hBEEF);

        do_write0(9'h000, 16'h1234);
        do_write0(9'h1FF, 16'hFFFF);
        do_read0(9'h000, rd, lat);
        chk("rd_addr0", rd, 16'h1234);
        do_read0(9'h1FF, rd, lat);
        chk("rd_addr511", rd, 16'hFFFF);
        do_read0(9'h001, rd, lat);
        chk("rd_addr1", rd, 16'h0000);
        do_read0(9'h1FE, rd, lat);
        chk("rd_addr510", rd, 16'h0000);

        // Backpressure: response held for 10 cycles while a write request is offered.
        bus0.rsp_ready = 1'b0;
        bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_addr = 9'h1A5;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        @(negedge clk);
        chk("bp_first", {bus0.rsp_valid, bus0.rsp_rdata}, {1'b1, 16'hBEEF});
        snap = e_cnt0;
        bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 9'h1A5; bus0.req_wdata = 16'h0000;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(bus0.rsp_valid === 1'b1 && bus0.rsp_rdata === 16'hBEEF && bus0.req_ready === 1'b0))
                bad++;
        end
        chk("bp_hold", bad, 0);
        chk("bp_no_ram_e", e_cnt0, snap);
        bus0.req_valid = 1'b0;
        bus0.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {bus0.rsp_valid, bus0.req_ready}, 2'b01);
        do_read0(9'h1A5, rd, lat);
        chk("bp_write_ignored", rd, 16'hBEEF);

        // Reset in the middle of init.
        rst_ = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        for (int i = 0; i < 200; i++) @(negedge clk);
        chk("mid_init_addr", {busy0, ram_w0, ram_addr0}, {2'b11, 9'd200});
        #2;
        rst_ = 1'b0;
        #1;
        chk("async_rst_pins", {ram_e0, ram_w0, ram_r0, ram_addr0, ram_din0}, 0);
        chk("async_rst_hs", {bus0.req_ready, bus0.rsp_valid, busy0}, 3'b001);
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        chk("first_cycle_ready1", {busy1, bus1.req_ready}, 2'b01);
        init_run(bad);
        chk("reinit_seq", bad, 0);
        chk("reinit_ready", bus0.req_ready, 1);
        do_read0(9'h1A5, rd, lat);
        chk("reinit_cleared", rd, 16'h0000);

        // No-init instance.
        bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_addr = 9'h003; bus1.req_wdata = 16'hA5A5;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = 9'h003; bus1.rsp_ready = 1'b1;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        @(negedge clk);
        chk("noinit_rd", {bus1.rsp_valid, bus1.rsp_rdata}, {1'b1, 16'hA5A5});
        @(negedge clk);
        chk("noinit_done", {bus1.rsp_valid, bus1.req_ready}, 2'b01);

        chk("w_r_exclusive", both_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
